// File: rtl/sd_sched_pkg.sv
// Shared types and helpers for the multi-track SD sector scheduler.
//   sched_state_t   : scheduler FSM states
//   SD_SECTOR_BYTES : bytes per SD block
//   track_base()    : first sector of a track's reserved region
package sd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

  localparam int unsigned SD_SECTOR_BYTES = 512;

  // Base sector of track 'id' when each track owns 'sectors' sectors.
  function automatic logic [63:0] track_base(input int unsigned id,
                                             input int unsigned sectors);
    return 64'(id) * 64'(sectors);
  endfunction

endpackage

// File: rtl/sd_track_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_vec   : per-track request levels
//   rr_next   : highest-priority track this round
//   grant_vec : one-hot winner (zero when no requests)
//   grant_id  : index of the winner
//   any       : at least one request present
module rr_arbiter #(
  parameter int NUM_TRACKS = 4,
  parameter int IDW        = $clog2(NUM_TRACKS)
) (
  input  logic [NUM_TRACKS-1:0] req_vec,
  input  logic [IDW-1:0]        rr_next,
  output logic [NUM_TRACKS-1:0] grant_vec,
  output logic [IDW-1:0]        grant_id,
  output logic                  any
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant_vec = '0;
    grant_id  = '0;
    found     = 1'b0;
    // Scan from rr_next upward, wrapping, and keep the first hit.
    for (int unsigned i = 0; i < NUM_TRACKS; i++) begin
      idx = (int'(rr_next) + i) % NUM_TRACKS;
      if (!found && req_vec[idx]) begin
        found          = 1'b1;
        grant_vec[idx] = 1'b1;
        grant_id       = IDW'(idx);
      end
    end
    any = found;
  end

endmodule

// File: rtl/sd_track_scheduler.sv
// Round-robin scheduler sharing one SD read/write command port between
// several audio tracks, each owning a contiguous sector region.
//   clk, rst          : system clock, synchronous active-high reset
//   req/req_write     : per-track request level and direction (1 = write)
//   rewind            : per-track pulse clearing that track's sector pointer
//   grant/done/wrapped: per-track one-cycle status pulses
//   active/active_id  : SD port ownership, grant cycle through done cycle
//   sd_ready          : SD controller idle
//   sd_rd/sd_wr       : one-cycle commands, sd_addr: sector for the command
module sd_track_scheduler
  import sd_sched_pkg::*;
#(
  parameter int NUM_TRACKS    = 4,
  parameter int TRACK_SECTORS = 65536,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_TRACKS-1:0]         req,
  input  logic [NUM_TRACKS-1:0]         req_write,
  input  logic [NUM_TRACKS-1:0]         rewind,
  output logic [NUM_TRACKS-1:0]         grant,
  output logic [NUM_TRACKS-1:0]         done,
  output logic [NUM_TRACKS-1:0]         wrapped,
  output logic [$clog2(NUM_TRACKS)-1:0] active_id,
  output logic                          active,
  input  logic                          sd_ready,
  output logic                          sd_rd,
  output logic                          sd_wr,
  output logic [ADDR_WIDTH-1:0]         sd_addr
);

  localparam int IDW = $clog2(NUM_TRACKS);
  localparam int PW  = $clog2(TRACK_SECTORS);

  sched_state_t          state_q;
  logic [IDW-1:0]        id_q, rr_next_q, active_id_q;
  logic                  dir_q, rwd_pend_q, active_q, sd_rd_q, sd_wr_q;
  logic [NUM_TRACKS-1:0] grant_q, done_q, wrapped_q;
  logic [ADDR_WIDTH-1:0] sd_addr_q, sd_addr_d;
  logic [PW-1:0]         ptr_q [NUM_TRACKS];
  logic [PW-1:0]         ptr_d [NUM_TRACKS];
  logic [NUM_TRACKS-1:0] wrap_d;

  logic [NUM_TRACKS-1:0] arb_vec;
  logic [IDW-1:0]        arb_id;
  logic                  arb_any;
  logic                  complete;

  rr_arbiter #(.NUM_TRACKS(NUM_TRACKS), .IDW(IDW)) u_arb (
    .req_vec  (req),
    .rr_next  (rr_next_q),
    .grant_vec(arb_vec),
    .grant_id (arb_id),
    .any      (arb_any)
  );

  assign complete = (state_q == WAIT_DONE) && sd_ready;

  // The owning track's pointer only moves at completion; a rewind seen
  // earlier in the transfer is parked in rwd_pend_q and wins over +1 there.
  always_comb begin
    logic busy;
    wrap_d = '0;
    for (int unsigned i = 0; i < NUM_TRACKS; i++) begin
      ptr_d[i] = ptr_q[i];
      busy = (state_q != IDLE) && (int'(id_q) == i);
      if (busy) begin
        if (complete) begin
          if (rewind[i] || rwd_pend_q) begin
            ptr_d[i] = '0;
          end else begin
            ptr_d[i]  = ptr_q[i] + 1'b1;
            wrap_d[i] = &ptr_q[i];
          end
        end
      end else if (rewind[i]) begin
        ptr_d[i] = '0;
      end
    end
  end

  // Address for a grant uses the post-rewind pointer so a same-cycle
  // rewind of the winner is honoured.
  assign sd_addr_d = ADDR_WIDTH'(track_base(32'(arb_id), TRACK_SECTORS)
                                 + 64'(ptr_d[arb_id]));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      rr_next_q   <= '0;
      active_id_q <= '0;
      dir_q       <= 1'b0;
      rwd_pend_q  <= 1'b0;
      active_q    <= 1'b0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      wrapped_q   <= '0;
      sd_addr_q   <= '0;
      for (int unsigned i = 0; i < NUM_TRACKS; i++) ptr_q[i] <= '0;
    end else begin
      grant_q   <= '0;
      done_q    <= '0;
      wrapped_q <= '0;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_TRACKS; i++) ptr_q[i] <= ptr_d[i];
      if (state_q != IDLE && rewind[id_q]) rwd_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (arb_any && sd_ready) begin
            id_q        <= arb_id;
            dir_q       <= req_write[arb_id];
            grant_q     <= arb_vec;
            active_q    <= 1'b1;
            active_id_q <= arb_id;
            sd_addr_q   <= sd_addr_d;
            rwd_pend_q  <= 1'b0;
            state_q     <= ISSUE;
          end else begin
            active_q <= 1'b0;
          end
        end
        ISSUE: begin
          sd_wr_q <= dir_q;
          sd_rd_q <= ~dir_q;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!sd_ready) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (sd_ready) begin
            done_q    <= NUM_TRACKS'(1) << id_q;
            wrapped_q <= wrap_d;
            rr_next_q <= (int'(id_q) == NUM_TRACKS - 1) ? '0 : id_q + 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;
  assign active    = active_q;
  assign active_id = active_id_q;
  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;
  assign sd_addr   = sd_addr_q;

endmodule

// File: tb/tb_sd_track_scheduler.sv
module tb_sd_track_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0, req_write = '0, rewind = '0;
  logic [3:0]  grant, done, wrapped;
  logic [1:0]  active_id;
  logic        active, sd_rd, sd_wr;
  logic        sd_ready;
  logic [31:0] sd_addr;

  int checks = 0;
  int failures = 0;
  int ov = 0;
  int lat = 0;
  logic outst = 1'b0;
  int sd_cnt = 0;

  always #5 clk = ~clk;

  sd_track_scheduler #(.NUM_TRACKS(4), .TRACK_SECTORS(8), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .rewind(rewind),
    .grant(grant), .done(done), .wrapped(wrapped), .active_id(active_id),
    .active(active), .sd_ready(sd_ready), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_addr(sd_addr)
  );

  // SD model: ready drops 2 cycles after a command, returns 20 cycles later.
  always @(posedge clk) begin
    if (rst) begin
      sd_ready <= 1'b1;
      sd_cnt   <= 0;
    end else begin
      if (sd_rd || sd_wr) sd_cnt <= 1;
      else if (sd_cnt != 0) sd_cnt <= sd_cnt + 1;
      if (sd_cnt == 2) sd_ready <= 1'b0;
      if (sd_cnt == 22) begin
        sd_ready <= 1'b1;
        sd_cnt   <= 0;
      end
    end
  end

  // Grants must be one-hot and never two without a done between them.
  always @(negedge clk) begin
    if (rst) outst = 1'b0;
    else begin
      if (!$onehot0(grant)) ov++;
      if (grant != 0) begin
        if (outst) ov++;
        outst = 1'b1;
      end
      if (done != 0) outst = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; rewind = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (grant == 0 && n < 60) begin @(negedge clk); n++; end
    chk({tag, "_grant_seen"}, 32'(grant != 0), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done == 0 && n < 80) begin @(negedge clk); n++; end
    lat = n;
    chk({tag, "_done_seen"}, 32'(done != 0), 32'd1);
  endtask

  // One complete transfer on track 'id' checked end to end.
  task automatic xfer(input string tag, input int id, input logic wr,
                      input logic flip, input logic rwd,
                      input logic [31:0] exp_addr, input logic exp_wrap);
    @(negedge clk);
    req[id] = 1'b1; req_write[id] = wr;
    @(negedge clk);
    wait_grant(tag);
    chk({tag, "_grant"}, 32'(grant), 32'(1) << id);
    chk({tag, "_active"}, 32'(active), 32'd1);
    chk({tag, "_active_id"}, 32'(active_id), 32'(id));
    req[id] = 1'b0;
    if (flip) req_write[id] = ~wr;
    @(negedge clk);
    chk({tag, "_cmd"}, {30'd0, sd_wr, sd_rd}, wr ? 32'd2 : 32'd1);
    chk({tag, "_addr"}, sd_addr, exp_addr);
    @(negedge clk);
    if (rwd) begin
      repeat (3) @(negedge clk);
      rewind[id] = 1'b1;
      @(negedge clk);
      rewind[id] = 1'b0;
    end
    wait_done(tag);
    chk({tag, "_done"}, 32'(done), 32'(1) << id);
    chk({tag, "_wrapped"}, 32'(wrapped), exp_wrap ? (32'(1) << id) : 32'd0);
    chk({tag, "_addr_hold"}, sd_addr, exp_addr);
    chk({tag, "_active_done"}, 32'(active), 32'd1);
    if (flip) req_write[id] = wr;
    @(negedge clk);
  endtask

  initial begin
    int rr_id [5];
    logic [31:0] rr_addr [5];
    int n;
    rr_id   = '{0, 1, 2, 3, 0};
    rr_addr = '{32'd0, 32'd8, 32'd16, 32'd24, 32'd1};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_outs", {8'd0, grant, done, wrapped, active_id, active, sd_rd, sd_wr}, 32'd0);
    chk("rst_addr", sd_addr, 32'd0);

    // Single load on track 2, then a second one
    xfer("load1", 2, 1'b0, 1'b0, 1'b0, 32'd16, 1'b0);
    xfer("load2", 2, 1'b0, 1'b0, 1'b0, 32'd17, 1'b0);

    // Round-robin with every request held
    do_reset();
    @(negedge clk);
    req = 4'b1111; req_write = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      wait_grant("rr");
      chk("rr_grant", 32'(grant), 32'(1) << rr_id[k]);
      if (k == 4) req = '0;
      @(negedge clk);
      chk("rr_addr", sd_addr, rr_addr[k]);
      wait_done("rr");
    end
    @(negedge clk);

    // Wrap on track 1
    do_reset();
    for (int k = 0; k < 8; k++)
      xfer("wrap", 1, 1'b1, 1'b0, 1'b0, 32'(8 + k), k == 7);
    xfer("wrap_next", 1, 1'b1, 1'b0, 1'b0, 32'd8, 1'b0);

    // Rewind of an idle track
    @(negedge clk);
    rewind[1] = 1'b1;
    @(negedge clk);
    rewind[1] = 1'b0;
    xfer("rwd_idle", 1, 1'b0, 1'b0, 1'b0, 32'd8, 1'b0);

    // Rewind during an active transfer on track 3 at pointer 5
    for (int k = 0; k < 5; k++)
      xfer("t3", 3, 1'b1, 1'b0, 1'b0, 32'(24 + k), 1'b0);
    xfer("rwd_act", 3, 1'b1, 1'b0, 1'b1, 32'd29, 1'b0);
    xfer("rwd_next", 3, 1'b1, 1'b0, 1'b0, 32'd24, 1'b0);

    // Direction latched at grant
    xfer("dir", 0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    // Reset in the middle of a transfer
    @(negedge clk);
    req[0] = 1'b1; req_write[0] = 1'b0;
    @(negedge clk);
    wait_grant("mid");
    req[0] = 1'b0;
    @(negedge clk);
    chk("mid_addr", sd_addr, 32'd1);
    n = 0;
    while (sd_ready && n < 20) begin @(negedge clk); n++; end
    chk("mid_busy", 32'(sd_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {8'd0, grant, done, wrapped, active_id, active, sd_rd, sd_wr}, 32'd0);
    chk("mid_rst_addr", sd_addr, 32'd0);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done != 0 || active) n++;
    end
    chk("mid_no_done", 32'(n), 32'd0);
    xfer("post_rst", 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    chk("no_overlap", 32'(ov), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_track_scheduler.md
# sd_track_scheduler

Sequences shared SD-card sector transfers for multiple audio tracks. Each track's store/load path raises a per-track sector request. The scheduler grants one request at a time, round-robin, and drives the SD controller's single read/write command port with the sector address for that track. It sits between the per-track sample buffers and the SD controller, replacing direct single-track `store_req`/`load_req` wiring. It runs on the 100 MHz system clock.

## Interface
Parameters:
- `NUM_TRACKS`, 4, number of requesting tracks (2..8)
- `TRACK_SECTORS`, 65536, sectors reserved per track; power of two
- `ADDR_WIDTH`, 32, SD block-address width

Ports:
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NUM_TRACKS  per-track request level; held until `grant` bit seen
- `req_write`  in  NUM_TRACKS  per-track direction: 1 = store (SD write), 0 = load (SD read)
- `rewind`  in  NUM_TRACKS  per-track one-cycle pulse; resets that track's sector pointer to 0
- `grant`  out  NUM_TRACKS  one-hot one-cycle pulse when a request is accepted
- `done`  out  NUM_TRACKS  one-hot one-cycle pulse when that track's transfer completes
- `wrapped`  out  NUM_TRACKS  one-cycle pulse, coincident with `done`, when the pointer wraps to 0
- `active_id`  out  $clog2(NUM_TRACKS)  track owning the SD port; steers byte-stream muxes
- `active`  out  1  high from `grant` through `done`, inclusive
- `sd_ready`  in  1  SD controller idle/ready
- `sd_rd`  out  1  one-cycle read command
- `sd_wr`  out  1  one-cycle write command
- `sd_addr`  out  ADDR_WIDTH  sector address; stable while `active`

## Operation
- Per-track pointer `ptr[i]` has width $clog2(TRACK_SECTORS).
- `sd_addr = i*TRACK_SECTORS + ptr[i]`, zero-extended to ADDR_WIDTH, unsigned, no overflow check.
- FSM states:
  - IDLE: if any `req` and `sd_ready`, the round-robin arbiter picks the first requester at or after `rr_next`. Latch the id and `req_write[id]`. Pulse `grant[id]`. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: assert `sd_wr` if the latched direction is 1, else `sd_rd`, for exactly one cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for `sd_ready` = 0, then go to WAIT_DONE.
  - WAIT_DONE: wait for `sd_ready` = 1. Then pulse `done[id]`, increment `ptr[id]` modulo TRACK_SECTORS, set `rr_next = id+1` modulo NUM_TRACKS, and go to IDLE.
- Wrap: incrementing from TRACK_SECTORS-1 gives 0 and asserts `wrapped[id]` with `done`.
- Rewind:
  - On an idle track, `ptr[i]` becomes 0 on the next edge.
  - On the active track, it takes effect at completion; the pointer becomes 0, not ptr+1, and `wrapped` is not pulsed.
  - Rewind and increment on the same edge: rewind wins.
- Requests:
  - A `req` deasserted after `grant` does not abort the transfer.
  - A `req` deasserted before `grant` is simply not served.
  - `req_write` is sampled only on the grant cycle.
- Reset:
  - All outputs are 0 and all `ptr` are 0.
  - `rr_next` is 0 and the FSM is in IDLE.
  - A reset mid-transfer abandons the transfer with no `done`. The SD controller shares `rst` and resets with the scheduler.

## Timing
- A request seen at edge N (IDLE, `sd_ready` = 1) gives `grant` during cycle N+1 and `sd_rd`/`sd_wr` during cycle N+2.
- `active` and `active_id` are valid from the grant cycle until the `done` cycle.
- `done` is asserted the cycle after `sd_ready` is first seen high in WAIT_DONE.
- The earliest next grant is the cycle after `done`, so back-to-back gap ≥ 1 idle cycle.
- `sd_addr` is registered, valid by the ISSUE cycle, and held until `done`.
- `grant`, `done`, `wrapped`, `sd_rd`, `sd_wr` are registered single-cycle pulses.
- `sd_ready` low at the grant edge: no effect. Readiness is checked only in IDLE, and the command is issued regardless in ISSUE.

## Structure
- Package `sd_sched_pkg` contains:
  - the FSM state enum `sched_state_t` {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE};
  - the `SD_SECTOR_BYTES = 512` constant;
  - the function `track_base(id, sectors)`.
- Sub-module `rr_arbiter`:
  - combinational;
  - inputs: NUM_TRACKS request vector and `rr_next`;
  - outputs: one-hot `grant_vec`, `grant_id`, `any`.
- Pointer array and FSM live in `sd_track_scheduler`.

## Test plan
Bench uses NUM_TRACKS=4, TRACK_SECTORS=8, and an SD model whose `sd_ready` drops 2 cycles after a command and rises 20 cycles later.
- Single load: `req[2]`=1, `req_write[2]`=0 → `grant` = 0100, then `sd_rd` one cycle with `sd_addr` = 16. `done[2]` about 23 cycles later. Second request gives `sd_addr` = 17.
- Round-robin: `req` = 1111 held → grants in order 0,1,2,3,0. Each `sd_addr` is base + pointer (0, 8, 16, 24, 1). Never two grants without an intervening `done`.
- Wrap: 8 consecutive stores on track 1 → addresses 8..15. The 8th `done` has `wrapped[1]`=1, and the next address is 8.
- Rewind during transfer: pulse `rewind[3]` while track 3 is active at ptr 5 → completion gives no `wrapped`, and the next track-3 address is 24.
- Reset mid-transfer: assert `rst` in WAIT_DONE → next cycle all outputs 0, `ptr` cleared, no `done`. The first post-reset request to track 0 gives address 0.
- Direction latch: toggle `req_write[0]` after `grant` → command and `active` behaviour follow the value at the grant edge.
